// File: rtl/div_unit_if.sv
// Request/response bus for div_unit.
//   master: requester side  (drives in_valid, op, A, B, out_ready)
//   slave : divider side    (drives in_ready, out_valid, result, div_zero)
interface div_unit_if #(
    parameter int unsigned size = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op;
    logic [size-1:0]   A;
    logic [size-1:0]   B;
    logic              out_valid;
    logic              out_ready;
    logic [size-1:0]   result;
    logic              div_zero;

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, result, div_zero
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, result, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider: DIV, DIVU, REM, REMU (RISC-V semantics).
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous abort of any operation in flight
//   bus    : div_unit_if.slave (in_valid/in_ready request with op, A, B;
//            out_valid/out_ready response with result, div_zero)
// Non-special requests take size CALC cycles plus one FIX cycle.
// Divide-by-zero and signed overflow are resolved at acceptance.
module div_unit #(
    parameter int unsigned size = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    div_unit_if.slave   bus
);
    localparam int unsigned CW = (size > 1) ? $clog2(size) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [size-1:0] MIN_NEG = {1'b1, {(size-1){1'b0}}};

    logic [1:0]      state_q,     state_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [size-1:0] rem_q,       rem_d;
    logic [size-1:0] quo_q,       quo_d;
    logic [size-1:0] div_q,       div_d;
    logic            neg_q,       neg_d;
    logic            is_rem_q,    is_rem_d;
    logic [size-1:0] result_q,    result_d;
    logic            div_zero_q,  div_zero_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q,  in_ready_d;

    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [size-1:0] a_abs;
    logic [size-1:0] b_abs;
    logic [size:0]   shifted;
    logic [size:0]   trial;
    logic [size-1:0] fix_val;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            neg_q       <= 1'b0;
            is_rem_q    <= 1'b0;
            result_q    <= '0;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            neg_q       <= neg_d;
            is_rem_q    <= is_rem_d;
            result_q    <= result_d;
            div_zero_q  <= div_zero_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state, datapath step and output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        neg_d       = neg_q;
        is_rem_d    = is_rem_q;
        result_d    = result_q;
        div_zero_d  = div_zero_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.A[size-1];
        b_neg     = signed_op & bus.B[size-1];
        a_abs     = a_neg ? (~bus.A + size'(1)) : bus.A;
        b_abs     = b_neg ? (~bus.B + size'(1)) : bus.B;

        // MSB of the (size+1)-bit difference is the borrow: set means restore
        shifted   = {rem_q, quo_q[size-1]};
        trial     = shifted - {1'b0, div_q};
        fix_val   = is_rem_q ? rem_q : quo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    is_rem_d   = bus.op[1];
                    in_ready_d = 1'b0;
                    if (bus.B == '0) begin
                        result_d    = bus.op[1] ? bus.A : '1;
                        div_zero_d  = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (signed_op && bus.A == MIN_NEG && bus.B == '1) begin
                        result_d    = bus.op[1] ? '0 : MIN_NEG;
                        div_zero_d  = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        rem_d      = '0;
                        quo_d      = a_abs;
                        div_d      = b_abs;
                        // Remainder takes the dividend's sign, quotient the XOR
                        neg_d      = bus.op[1] ? a_neg : (a_neg ^ b_neg);
                        cnt_d      = '0;
                        div_zero_d = 1'b0;
                        state_d    = S_CALC;
                    end
                end
            end
            S_CALC: begin
                quo_d = {quo_q[size-2:0], ~trial[size]};
                rem_d = trial[size] ? shifted[size-1:0] : trial[size-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(size - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d    = neg_q ? (~fix_val + size'(1)) : fix_val;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            default: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
        endcase

        // Abort wins over any request or consume in the same cycle
        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, randomized operations
// against an arithmetic reference model, flush and mid-operation reset.
module tb_div_unit;
    localparam int unsigned W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    div_unit_if #(.size(W)) bus ();

    div_unit #(.size(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected result, div_zero and acceptance-to-out_valid latency
    function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, output logic [W-1:0] res,
                                      output logic dz, output int lat);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa  = a;
        sb  = b;
        dz  = (b == '0);
        lat = W + 2;
        if (b == '0) begin
            res = op[1] ? a : '1;
            lat = 1;
        end else if (!op[0] && a == MIN_NEG && b == '1) begin
            res = op[1] ? '0 : MIN_NEG;
            lat = 1;
        end else begin
            case (op)
                2'd0:    res = W'(sa / sb);
                2'd1:    res = a / b;
                2'd2:    res = W'(sa % sb);
                default: res = a % b;
            endcase
        end
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W-1:0] exp_res;
        logic         exp_dz;
        int           exp_lat;
        int           n;
        string        t;
        ref_model(op, a, b, exp_res, exp_dz, exp_lat);
        t = $sformatf("op%0d_%08h_%08h", op, a, b);
        check({t, "_in_ready_idle"}, W'(bus.in_ready), W'(1));
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.A        = a;
        bus.B        = b;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                // Scramble operands after acceptance; the DUT must ignore them
                bus.in_valid = 1'b0;
                bus.A        = $urandom;
                bus.B        = $urandom;
                bus.op       = 2'($urandom);
            end
        end while (!bus.out_valid && n < 100);
        check({t, "_latency"},  W'(n), W'(exp_lat));
        check({t, "_result"},   bus.result, exp_res);
        check({t, "_div_zero"}, W'(bus.div_zero), W'(exp_dz));
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
        end
        if (hold > 0) begin
            check({t, "_hold_result"},   bus.result, exp_res);
            check({t, "_hold_valid"},    W'(bus.out_valid), W'(1));
            check({t, "_hold_in_ready"}, W'(bus.in_ready), W'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({t, "_consumed_valid"},    W'(bus.out_valid), W'(0));
        check({t, "_consumed_in_ready"}, W'(bus.in_ready), W'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         seen;

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 2'd0;
        bus.A         = '0;
        bus.B         = '0;

        @(negedge clk);
        check("reset_in_ready",  W'(bus.in_ready), W'(1));
        check("reset_out_valid", W'(bus.out_valid), W'(0));
        check("reset_result",    bus.result, '0);
        check("reset_div_zero",  W'(bus.div_zero), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(2'd1, 32'd100, 32'd7, 10);
        run_op(2'd3, 32'd100, 32'd7, 0);
        run_op(2'd0, -32'sd7, 32'd2, 0);
        run_op(2'd2, -32'sd7, 32'd2, 1);
        run_op(2'd2, 32'd7, -32'sd2, 0);
        run_op(2'd1, 32'd5, 32'd0, 2);
        run_op(2'd3, 32'd5, 32'd0, 0);
        run_op(2'd0, MIN_NEG, 32'hFFFF_FFFF, 0);
        run_op(2'd2, MIN_NEG, 32'hFFFF_FFFF, 0);
        run_op(2'd1, MIN_NEG, 32'hFFFF_FFFF, 0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd3, 32'hFFFF_FFFF, 32'd1, 0);

        // Randomized operations with a bias toward boundary operands
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       b = '1;
                2:       b = W'($urandom_range(1, 15));
                3:       b = MIN_NEG;
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       a = MIN_NEG;
                1:       a = W'($urandom_range(0, 50));
                default: a = $urandom;
            endcase
            run_op(op, a, b, int'($urandom_range(0, 3)));
        end

        // Flush at CALC iteration 10, with a competing request in the same cycle
        bus.in_valid = 1'b1;
        bus.op       = 2'd1;
        bus.A        = 32'd1000;
        bus.B        = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", W'(bus.out_valid), W'(0));
        check("flush_in_ready",  W'(bus.in_ready), W'(1));
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush_no_result", W'(seen), W'(0));
        run_op(2'd1, 32'd1000, 32'd3, 0);

        // Asynchronous reset in the middle of CALC
        bus.in_valid = 1'b1;
        bus.op       = 2'd0;
        bus.A        = 32'd12345;
        bus.B        = 32'd17;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", W'(bus.out_valid), W'(0));
        check("midreset_result",    bus.result, '0);
        check("midreset_div_zero",  W'(bus.div_zero), W'(0));
        check("midreset_in_ready",  W'(bus.in_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("midreset_discarded", W'(seen), W'(0));
        run_op(2'd0, -32'sd7, 32'd2, 0);
        run_op(2'd2, 32'd12345, 32'd17, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: size, default 32, operand and result width in bits.
REQ-002 Port: clk  input  1  rising-edge clock, the block's only clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: flush  input  1  synchronous abort of any operation in flight.
REQ-005 Port: in_valid  input  1  request strobe; qualifies op, A, B.
REQ-006 Port: in_ready  output  1  high only in IDLE; a request is accepted on a clock edge where in_valid & in_ready.
REQ-007 Port: op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 Port: A  input  size  dividend.
REQ-009 Port: B  input  size  divisor.
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: result  output  size  quotient or remainder, per op.
REQ-013 Port: div_zero  output  1  the completed request had B == 0; valid while out_valid is high.

Function
REQ-014 The block SHALL implement a four-state machine: IDLE, CALC, FIX, DONE.
REQ-015 IDLE SHALL latch op, A and B on acceptance.
  - Signed ops (00, 10) latch the absolute values of A and B, plus the operand signs.
  - DIV negates the quotient if sign(A) XOR sign(B); REM negates the remainder if sign(A).
REQ-016 Special cases SHALL be resolved at the acceptance edge, going IDLE->DONE directly (out_valid high the next cycle):
  - B==0: DIV/DIVU give all-ones; REM/REMU give A; div_zero=1.
  - DIV with A = -2^(size-1) and B = -1: result -2^(size-1).
  - REM with A = -2^(size-1) and B = -1: result 0.
REQ-017 All other requests SHALL go IDLE->CALC, with the iteration counter loaded to 0.
REQ-018 CALC SHALL execute one restoring-division step per cycle.
  - Step: shift {rem,quo} left by one; trial-subtract divisor from rem.
  - Trial result non-negative: keep it and set quo LSB to 1. Otherwise restore rem and set quo LSB to 0.
  - The trial subtraction SHALL be size+1 bits wide so no borrow is lost.
REQ-019 After exactly size CALC cycles the state SHALL go to FIX.
REQ-020 FIX SHALL apply sign correction (two's complement negate), select quo or rem per op, register result, and go to DONE.
REQ-021 Latency: out_valid SHALL rise exactly size+2 cycles after the acceptance edge for non-special requests (34 for size=32), and 1 cycle after it for special cases.
REQ-022 DONE SHALL hold out_valid, result and div_zero stable until out_ready is high on a clock edge; at that edge the state goes to IDLE.
REQ-023 in_ready SHALL be low in CALC, FIX and DONE; a new request is not accepted in the same cycle a result is consumed.
REQ-024 flush SHALL force IDLE on the next edge from any state and drop out_valid without delivering a result.
REQ-025 flush SHALL take priority over in_valid and out_ready in the same cycle; a request presented during flush is not accepted.
REQ-026 Operand inputs A, B and op SHALL be ignored outside the acceptance edge.

Reset
REQ-027 rst_n low SHALL immediately set state to IDLE and clear out_valid, div_zero, result, the counter and all internal registers to 0.
REQ-028 in_ready SHALL be high during and after reset, and an operation in flight at reset SHALL be discarded.

Verification
REQ-029 DIVU, A=100, B=7 -> out_valid after 34 cycles, result=14; repeat with REMU -> result=2.
REQ-030 DIV, A=-7, B=2 -> result=-3 (0xFFFFFFFD); REM -> result=-1; REM with A=7, B=-2 -> result=1.
REQ-031 DIVU, A=5, B=0 -> out_valid after 1 cycle, result=0xFFFFFFFF, div_zero=1; REMU -> result=5.
REQ-032 DIV, A=0x80000000, B=0xFFFFFFFF -> result=0x80000000 after 1 cycle; REM -> 0, div_zero=0.
REQ-033 out_ready held low 10 cycles in DONE -> result stable, in_ready low; then out_ready high -> IDLE, in_ready high next cycle.
REQ-034 flush asserted at CALC iteration 10 -> IDLE next cycle, no out_valid; rst_n pulsed low mid-CALC -> all outputs 0, in_ready high, next request completes correctly.
